// File: rtl/rescale_relu_arbiter.sv
`default_nettype none
// ============================================================================
// rescale_relu_arbiter : round-robin sharing of one 2-stage RescaleReLu unit
// Revision 1.0
// ============================================================================

module rescale_relu #(
  parameter logic signed [7:0] M0 = 8'sd59,
  parameter logic [7:0]        N  = 8'd11
) (
  input  logic               clk,
  input  logic               en_i,
  input  logic signed [31:0] x_i,
  output logic signed [7:0]  y_o
);
  logic signed [39:0] prod_q, prod_d;
  logic signed [39:0] shr;
  logic signed [7:0]  y_q, y_d;

  always_comb begin
    prod_d = 40'(x_i) * 40'(M0);
    shr    = prod_q >>> N;
    if (shr[39]) begin
      y_d = 8'sd0;
    end else if (shr > 40'sd127) begin
      y_d = 8'sd127;
    end else begin
      y_d = shr[7:0];
    end
  end

  // Datapath registers carry no reset: their contents only matter under a valid bit.
  always_ff @(posedge clk) begin
    if (en_i) begin
      prod_q <= prod_d;
      y_q    <= y_d;
    end
  end

  assign y_o = y_q;
endmodule

module rescale_relu_arbiter #(
  parameter int                NUM_REQ = 4,
  parameter logic signed [7:0] M0      = 8'sd59,
  parameter logic [7:0]        N       = 8'd11,
  parameter int                ID_W    = $clog2(NUM_REQ)
) (
  input  logic                    clk,
  input  logic                    rst_b,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [32*NUM_REQ-1:0]   req_data,
  output logic [NUM_REQ-1:0]      req_ready,
  output logic                    out_valid,
  output logic signed [7:0]       out_data,
  output logic [ID_W-1:0]         out_id,
  input  logic                    out_ready,
  output logic                    busy
);
  localparam logic [ID_W:0] NUM_REQ_EXT = (ID_W+1)'(NUM_REQ);

  logic            v0_q, v1_q;
  logic [ID_W-1:0] id0_q, id1_q;
  logic [ID_W-1:0] last_q;

  logic               adv;
  logic               any_grant;
  logic [ID_W-1:0]    win_idx;
  logic [ID_W:0]      cand;
  logic signed [31:0] sel_data;

  assign adv = out_ready | ~v1_q;

  // Search starts one past the previous winner, wrapping at NUM_REQ.
  always_comb begin
    req_ready = '0;
    any_grant = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = {1'b0, last_q} + (ID_W+1)'(k);
      if (cand >= NUM_REQ_EXT) begin
        cand = cand - NUM_REQ_EXT;
      end
      if (!any_grant && req_valid[cand[ID_W-1:0]]) begin
        any_grant = 1'b1;
        win_idx   = cand[ID_W-1:0];
      end
    end
    if (!adv || rst_b) begin
      any_grant = 1'b0;
      win_idx   = '0;
    end
    if (any_grant) begin
      req_ready[win_idx] = 1'b1;
    end
  end

  assign sel_data = req_data[32*win_idx +: 32];

  always_ff @(posedge clk) begin
    if (rst_b) begin
      v0_q   <= 1'b0;
      v1_q   <= 1'b0;
      id0_q  <= '0;
      id1_q  <= '0;
      last_q <= ID_W'(NUM_REQ - 1);
    end else if (adv) begin
      v0_q  <= any_grant;
      id0_q <= win_idx;
      v1_q  <= v0_q;
      id1_q <= id0_q;
      if (any_grant) begin
        last_q <= win_idx;
      end
    end
  end

  rescale_relu #(
    .M0 (M0),
    .N  (N)
  ) u_rescale (
    .clk  (clk),
    .en_i (adv),
    .x_i  (sel_data),
    .y_o  (out_data)
  );

  assign out_valid = v1_q;
  assign out_id    = id1_q;
  assign busy      = v0_q | v1_q;
endmodule
`default_nettype wire

// File: tb/tb_rescale_relu_arbiter.sv
`default_nettype none
// ============================================================================
// tb_rescale_relu_arbiter : directed scenarios plus randomized model check
// Revision 1.0
// ============================================================================
module tb_rescale_relu_arbiter;
  localparam int NR = 4;

  logic            clk = 1'b0;
  logic            rst_b;
  logic [NR-1:0]   req_valid;
  logic [32*NR-1:0] req_data;
  logic [NR-1:0]   req_ready;
  logic            out_valid;
  logic signed [7:0] out_data;
  logic [1:0]      out_id;
  logic            out_ready;
  logic            busy;

  int n_assert = 0;
  int n_fail   = 0;

  typedef struct {
    int id;
    int val;
    int age;
  } ent_t;
  ent_t pipe[$];

  always #5 clk = ~clk;

  rescale_relu_arbiter #(.NUM_REQ(NR)) dut (
    .clk       (clk),
    .rst_b     (rst_b),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_id    (out_id),
    .out_ready (out_ready),
    .busy      (busy)
  );

  function automatic int rescale_ref(input int x);
    longint p;
    p = longint'(x) * 59;
    p = p >>> 11;
    if (p < 0) return 0;
    if (p > 127) return 127;
    return int'(p);
  endfunction

  task automatic set_word(input int i, input int v);
    req_data[32*i +: 32] = v;
  endtask

  // Leaves the bench at a falling edge with reset just released.
  task automatic do_reset();
    @(negedge clk);
    rst_b = 1'b1; req_valid = '0; out_ready = 1'b1;
    @(negedge clk);
    rst_b = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_b = 1'b1; req_valid = '1; out_ready = 1'b1;
    for (int i = 0; i < NR; i++) set_word(i, i);
    #1;
    n_assert++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_ready_in_reset: got %b want 0000", req_ready); end
    @(negedge clk);
    rst_b = 1'b0;
    #1;
    n_assert++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_assert++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_assert++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL reset_first_priority: got %b want 0001", req_ready); end
    @(negedge clk);
    req_valid = '0;
  endtask

  task automatic test_latency_arith();
    int xs[3];
    int ex[3];
    xs = '{1000, 100000, -40000};
    ex = '{28, 127, 0};
    do_reset();
    for (int c = 0; c < 6; c++) begin
      if (c != 0) @(negedge clk);
      if (c < 3) begin req_valid = 4'b0001; set_word(0, xs[c]); end
      else req_valid = '0;
      #1;
      if (c < 3) begin
        n_assert++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL lat_ready c%0d: got %b want 0001", c, req_ready); end
      end
      if (c >= 2 && c < 5) begin
        n_assert++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL lat_valid c%0d: got %b want 1", c, out_valid); end
        n_assert++; if (out_data !== 8'(ex[c-2])) begin n_fail++; $display("FAIL lat_data c%0d: got %0d want %0d", c, out_data, ex[c-2]); end
        n_assert++; if (out_id !== 2'd0) begin n_fail++; $display("FAIL lat_id c%0d: got %0d want 0", c, out_id); end
      end else begin
        n_assert++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL lat_idle c%0d: got %b want 0", c, out_valid); end
      end
    end
  endtask

  task automatic test_round_robin();
    int ex[4];
    ex = '{7, 14, 22, 29};
    do_reset();
    for (int i = 0; i < NR; i++) set_word(i, 256 * (i + 1));
    for (int c = 0; c < 10; c++) begin
      if (c != 0) @(negedge clk);
      req_valid = (c < 8) ? 4'b1111 : 4'b0000;
      #1;
      if (c < 8) begin
        n_assert++; if (req_ready !== 4'(1 << (c % 4))) begin n_fail++; $display("FAIL rr_grant c%0d: got %b want %b", c, req_ready, 4'(1 << (c % 4))); end
      end
      if (c >= 2) begin
        n_assert++; if (out_valid !== 1'b1 || out_id !== 2'((c - 2) % 4)) begin n_fail++; $display("FAIL rr_id c%0d: got v%b id%0d want v1 id%0d", c, out_valid, out_id, (c - 2) % 4); end
        n_assert++; if (out_data !== 8'(ex[(c - 2) % 4])) begin n_fail++; $display("FAIL rr_data c%0d: got %0d want %0d", c, out_data, ex[(c - 2) % 4]); end
      end
    end
  endtask

  task automatic test_backpressure();
    int sent;
    int got;
    sent = 0; got = 0;
    do_reset();
    for (int c = 0; c < 16; c++) begin
      if (c != 0) @(negedge clk);
      out_ready = !(c >= 3 && c <= 5);
      req_valid = (sent < 6) ? 4'b0100 : 4'b0000;
      set_word(2, 500 * (sent + 1));
      #1;
      n_assert++; if ((req_ready & 4'b1011) !== 4'b0000) begin n_fail++; $display("FAIL bp_stray_grant c%0d: got %b", c, req_ready); end
      if (c >= 3 && c <= 5) begin
        n_assert++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL bp_freeze_ready c%0d: got %b want 0000", c, req_ready); end
        n_assert++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_freeze_valid c%0d: got %b want 1", c, out_valid); end
        n_assert++; if (out_data !== 8'(rescale_ref(500 * (got + 1))) || out_id !== 2'd2) begin n_fail++; $display("FAIL bp_freeze_hold c%0d: got %0d/%0d want %0d/2", c, out_data, out_id, rescale_ref(500 * (got + 1))); end
      end
      if (out_valid && out_ready) begin
        n_assert++;
        if (got >= 6) begin n_fail++; $display("FAIL bp_extra_output c%0d: got %0d want none", c, out_data); end
        else if (out_data !== 8'(rescale_ref(500 * (got + 1))) || out_id !== 2'd2) begin n_fail++; $display("FAIL bp_order c%0d: got %0d/%0d want %0d/2", c, out_data, out_id, rescale_ref(500 * (got + 1))); end
        got++;
      end
      if (req_valid[2] && req_ready[2]) sent++;
    end
    n_assert++; if (got != 6) begin n_fail++; $display("FAIL bp_count: got %0d want 6", got); end
    out_ready = 1'b1;
  endtask

  task automatic test_bubble_fill();
    do_reset();
    for (int c = 0; c < 7; c++) begin
      if (c != 0) @(negedge clk);
      out_ready = (c >= 4);
      req_valid = (c < 4) ? 4'b0010 : 4'b0000;
      set_word(1, (c == 0) ? 3000 : (c == 1) ? 2000 : 9999);
      #1;
      if (c < 2) begin
        n_assert++; if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL bub_grant c%0d: got %b want 0010", c, req_ready); end
        n_assert++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bub_early_valid c%0d: got %b want 0", c, out_valid); end
      end else if (c < 6) begin
        n_assert++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL bub_full_ready c%0d: got %b want 0000", c, req_ready); end
        n_assert++; if (out_valid !== 1'b1 || out_id !== 2'd1) begin n_fail++; $display("FAIL bub_valid c%0d: got v%b id%0d want v1 id1", c, out_valid, out_id); end
        n_assert++; if (out_data !== ((c < 5) ? 8'd86 : 8'd57)) begin n_fail++; $display("FAIL bub_data c%0d: got %0d want %0d", c, out_data, (c < 5) ? 86 : 57); end
      end else begin
        n_assert++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bub_drained c%0d: got %b want 0", c, out_valid); end
      end
      if (c >= 1 && c < 6) begin
        n_assert++; if (busy !== 1'b1) begin n_fail++; $display("FAIL bub_busy c%0d: got %b want 1", c, busy); end
      end else if (c == 6) begin
        n_assert++; if (busy !== 1'b0) begin n_fail++; $display("FAIL bub_idle c%0d: got %b want 0", c, busy); end
      end
    end
  endtask

  task automatic test_rotation_skip();
    logic [3:0] exr[4];
    int exid[3];
    int exd[3];
    exr  = '{4'b0010, 4'b1000, 4'b0010, 4'b0000};
    exid = '{1, 3, 1};
    exd  = '{28, 72, 43};
    do_reset();
    for (int c = 0; c < 6; c++) begin
      if (c != 0) @(negedge clk);
      req_valid = (c == 0) ? 4'b0010 : (c < 3) ? 4'b1010 : 4'b0000;
      set_word(1, (c == 0) ? 1000 : 1500);
      set_word(3, 2500);
      #1;
      if (c < 4) begin
        n_assert++; if (req_ready !== exr[c]) begin n_fail++; $display("FAIL rot_grant c%0d: got %b want %b", c, req_ready, exr[c]); end
      end
      if (c >= 2 && c < 5) begin
        n_assert++; if (out_valid !== 1'b1 || out_id !== 2'(exid[c-2])) begin n_fail++; $display("FAIL rot_id c%0d: got v%b id%0d want v1 id%0d", c, out_valid, out_id, exid[c-2]); end
        n_assert++; if (out_data !== 8'(exd[c-2])) begin n_fail++; $display("FAIL rot_data c%0d: got %0d want %0d", c, out_data, exd[c-2]); end
      end else begin
        n_assert++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rot_idle c%0d: got %b want 0", c, out_valid); end
      end
    end
  endtask

  task automatic test_reset_midflight();
    do_reset();
    set_word(0, 1000); set_word(1, 1000); set_word(2, 1000);
    for (int c = 0; c < 4; c++) begin
      if (c != 0) @(negedge clk);
      rst_b     = (c == 2);
      req_valid = (c < 2) ? 4'b0001 : 4'b0110;
      #1;
      if (c < 2) begin
        n_assert++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL mid_grant c%0d: got %b want 0001", c, req_ready); end
      end else if (c == 2) begin
        n_assert++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL mid_ready_in_reset: got %b want 0000", req_ready); end
      end else begin
        n_assert++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_out_valid: got %b want 0", out_valid); end
        n_assert++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_busy: got %b want 0", busy); end
        n_assert++; if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL mid_next_grant: got %b want 0010", req_ready); end
      end
    end
    @(negedge clk);
    req_valid = '0;
  endtask

  // Results queue with age = advances since grant; age 2 is the visible output.
  task automatic test_random();
    int          last_m;
    logic [NR-1:0] vld;
    int          dat[NR];
    logic        front_full;
    logic        adv_m;
    int          win;
    int          idx;
    logic [NR-1:0] exp_ready;
    last_m = NR - 1;
    vld = '0;
    for (int i = 0; i < NR; i++) dat[i] = 0;
    pipe.delete();
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if (c != 0) @(negedge clk);
      for (int i = 0; i < NR; i++) begin
        if (!vld[i]) begin
          if ($urandom_range(0, 1) == 1) begin
            vld[i] = 1'b1;
            if ($urandom_range(0, 1) == 1) dat[i] = int'($urandom_range(0, 8000)) - 4000;
            else dat[i] = int'($urandom);
          end
        end else if ($urandom_range(0, 15) == 0) begin
          vld[i] = 1'b0;
        end
      end
      out_ready = ($urandom_range(0, 3) != 0);
      req_valid = vld;
      for (int i = 0; i < NR; i++) set_word(i, dat[i]);

      front_full = (pipe.size() > 0) && (pipe[0].age == 2);
      adv_m = out_ready || !front_full;
      win = -1;
      if (adv_m) begin
        for (int k = 1; k <= NR; k++) begin
          idx = (last_m + k) % NR;
          if (win < 0 && vld[idx]) win = idx;
        end
      end
      exp_ready = (win >= 0) ? NR'(1) << win : '0;
      #1;
      n_assert++; if (req_ready !== exp_ready) begin n_fail++; $display("FAIL rnd_grant c%0d: got %b want %b", c, req_ready, exp_ready); end
      n_assert++; if (out_valid !== front_full) begin n_fail++; $display("FAIL rnd_valid c%0d: got %b want %b", c, out_valid, front_full); end
      if (front_full) begin
        n_assert++; if (out_id !== 2'(pipe[0].id) || out_data !== 8'(pipe[0].val)) begin n_fail++; $display("FAIL rnd_result c%0d: got %0d/%0d want %0d/%0d", c, out_id, out_data, pipe[0].id, pipe[0].val); end
      end
      n_assert++; if (busy !== (pipe.size() > 0)) begin n_fail++; $display("FAIL rnd_busy c%0d: got %b want %b", c, busy, pipe.size() > 0); end

      if (adv_m) begin
        if (front_full) void'(pipe.pop_front());
        foreach (pipe[j]) pipe[j].age++;
        if (win >= 0) begin
          pipe.push_back('{win, rescale_ref(dat[win]), 1});
          last_m = win;
          vld[win] = 1'b0;
        end
      end
    end
    @(negedge clk);
    req_valid = '0;
    out_ready = 1'b1;
  endtask

  initial begin
    rst_b = 1'b1; req_valid = '0; req_data = '0; out_ready = 1'b1;
    test_reset();
    test_latency_arith();
    test_round_robin();
    test_backpressure();
    test_bubble_fill();
    test_rotation_skip();
    test_reset_midflight();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
`default_nettype wire

// File: doc/rescale_relu_arbiter.md
# rescale_relu_arbiter

Round-robin scheduler that shares one RescaleReLu requantization unit (32-bit accumulator in, 8-bit post-ReLU activation out, 2-cycle enable-gated pipeline) among NUM_REQ accumulator sources, such as parallel conv channels.

- Grants at most one request per cycle.
- Carries the winner's ID alongside the data through the pipeline.
- Stalls the whole pipeline, through the unit's `en`, when the downstream consumer applies backpressure.

## Interface
- `NUM_REQ`, default 4: number of requesters, 2..16.
- `M0`, default 8'sd59: multiplier, passed through to the internal RescaleReLu.
- `N`, default 8'd11: right-shift amount, passed through to the internal RescaleReLu.
- `ID_W`, default `$clog2(NUM_REQ)`: width of the requester ID.
- `clk`, in, 1: single clock, rising edge.
- `rst_b`, in, 1: reset, synchronous, active-high (1 = reset).
- `req_valid`, in, NUM_REQ: per-requester data valid.
- `req_data`, in, 32*NUM_REQ: signed accumulators; requester i occupies bits [32i+31:32i].
- `req_ready`, out, NUM_REQ: one-hot grant, combinational.
- `out_valid`, out, 1: result valid.
- `out_data`, out, 8: signed result, range 0..127.
- `out_id`, out, ID_W: index of the requester that produced `out_data`.
- `out_ready`, in, 1: consumer accepts the result.
- `busy`, out, 1: at least one stage of the pipeline is valid.

## Operation
- Internal state:
  - Valid bits `v0` and `v1`.
  - ID registers `id0` and `id1`, aligned with the two RescaleReLu stages.
  - Round-robin pointer `last` (ID_W bits).
- The datapath computes `out_data = clamp(max(0, (x*M0) >>> N), 0, 127)`, where x is the accepted `req_data` word.
- `adv = out_ready | ~v1`. `adv` drives the RescaleReLu `en` and the shifting of `v`/`id`.
- Arbitration, combinational:
  - When `adv = 1`, search `req_valid` starting at index `last+1` mod NUM_REQ.
  - The first set bit i wins: `req_ready[i] = 1`, all other bits 0.
  - When `adv = 0`, `req_ready` is all 0.
- A transfer happens on requester i when `req_valid[i] & req_ready[i]`.
- Mux: the datapath input is the winner's `req_data` slice. With no winner the input is don't-care and `v0` loads 0.
- On `adv = 1`:
  - `v0` ← (any grant), `id0` ← winner index.
  - `v1` ← `v0`, `id1` ← `id0`.
  - `last` ← winner index, only if there was a grant.
- On `adv = 0`: all of `v`, `id`, `last` and the datapath registers hold.
- Outputs: `out_valid = v1`, `out_id = id1`, `out_data` = RescaleReLu output. `busy = v0 | v1`.
- Requesters hold `req_valid` and data until they are granted. Dropping `req_valid` before a grant is legal and simply withdraws the request.

## Timing
- Reset, synchronous, active-high: `v0 = v1 = 0`, `id0 = id1 = 0`, `last = NUM_REQ-1` (requester 0 has first priority).
  - `out_valid = 0`, `busy = 0`.
  - `out_data` after reset is don't-care while `out_valid = 0`.
  - Reset mid-flight discards in-flight results with no output.
  - `req_ready` is 0 during the cycle in which `rst_b = 1`.
- Latency: data granted in cycle t appears with `out_valid = 1` in cycle t+2, provided `out_ready` stays high in cycles t and t+1.
- Throughput: one result per cycle with sustained `out_ready = 1`.
- Backpressure:
  - `out_valid` is high and `out_ready` is low → the pipeline freezes.
  - `out_data`/`out_id` stay stable until accepted.
  - No new grants are issued during the freeze.
  - Outputs never drop or duplicate.
- Bubble collapse: while `v1 = 0`, the pipeline advances even with `out_ready` low, so `v0` fills toward `v1`.
- Simultaneous accept and grant in the same cycle is allowed. Capacity is two results in flight.
- Fairness: with all requesters continuously valid, the grant order is 0,1,…,NUM_REQ-1,0,… Each requester waits at most NUM_REQ-1 grant cycles.
- Single requester: the same requester can be granted on consecutive cycles.

## Test plan
- Latency/arith (M0=59, N=11): req 0 sends 1000, then 100000, then -40000 back to back with `out_ready = 1` → `out_valid` in cycles t+2..t+4 with `out_data` 28, 127, 0 and `out_id` 0,0,0.
- Round-robin (NUM_REQ=4): all four requesters valid for 8 cycles with data 0x100·(i+1) → grant sequence 0,1,2,3,0,1,2,3; `out_id` repeats that sequence starting 2 cycles later; `out_data` 7, 14, 22, 29 (256·(i+1)·59 >> 11).
- Backpressure: stream from req 2, `out_ready` low for 3 cycles while `out_valid = 1` → `out_data`/`out_id` held constant; `req_ready` = 0 throughout; after release, results arrive in order with none lost or duplicated.
- Bubble fill: `out_ready = 0` from reset, req 1 sends two words → `v1` then `v0` fill; `req_ready` goes low after the second grant; `busy = 1`. Raising `out_ready` drains both results in 2 cycles.
- Rotation skip: only req 3 and req 1 valid, `last = 1` → req 3 granted, then req 1; idle requesters 0 and 2 are skipped with no bubble.
- Reset mid-flight: assert `rst_b` for 1 cycle with two results in flight → the next cycle has `out_valid = 0` and `busy = 0`; the next grant goes to the lowest valid index ≥ 0.
